// File: rtl/riscmakers_dcache_mem_responder_pkg.sv
// Shared types and constants for the data-cache memory responder model.
package dcache_pkg;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned XLEN_BYTES           = XLEN / 8;
  localparam int unsigned XLEN_ALIGN_BYTES     = 2;
  localparam int unsigned PLEN                 = 32;
  localparam int unsigned DCACHE_LINE_WIDTH    = 128;
  localparam int unsigned DCACHE_OFFSET_WIDTH  = 4;
  localparam int unsigned DCACHE_TID_WIDTH     = 4;
  localparam int unsigned RESP_LATENCY_WIDTH   = 4;
  localparam int unsigned RESP_DEFAULT_LATENCY = 2;

  typedef enum logic [2:0] {
    DCACHE_LOAD_REQ   = 3'd0,
    DCACHE_STORE_REQ  = 3'd1,
    DCACHE_ATOMIC_REQ = 3'd2,
    DCACHE_INT_REQ    = 3'd3
  } dcache_req_type_t;

  typedef enum logic [2:0] {
    DCACHE_LOAD_ACK   = 3'd0,
    DCACHE_STORE_ACK  = 3'd1,
    DCACHE_ATOMIC_ACK = 3'd2,
    DCACHE_INV_REQ    = 3'd3,
    DCACHE_INT_ACK    = 3'd4
  } dcache_rtrn_type_t;

  typedef struct packed {
    dcache_req_type_t            rtype;
    logic [2:0]                  size;
    logic [PLEN-1:0]             paddr;
    logic [XLEN-1:0]             data;
    logic [DCACHE_TID_WIDTH-1:0] tid;
    logic                        nc;
  } dcache_req_t;

  typedef struct packed {
    dcache_rtrn_type_t            rtype;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic [DCACHE_TID_WIDTH-1:0]  tid;
  } dcache_rtrn_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } responder_state_t;

  // Byte enables within one XLEN word; offset is the byte address inside that word.
  function automatic logic [XLEN_BYTES-1:0] store_be(input logic [2:0] size,
                                                     input logic [XLEN_ALIGN_BYTES-1:0] offset);
    logic [XLEN_BYTES-1:0] base;
    unique case (size)
      3'd0:    base = XLEN_BYTES'(1);
      3'd1:    base = XLEN_BYTES'(3);
      default: base = '1;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/riscmakers_line_sram.sv
// Line-wide backing store: combinational read, byte-enabled synchronous write, no reset.
module riscmakers_line_sram #(
  parameter int unsigned Lines = 1024,
  parameter int unsigned Width = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Lines)-1:0] waddr_i,
  input  logic [Width/8-1:0]       wbe_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Lines)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Lines];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < Width / 8; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscmakers_dcache_mem_responder.sv
// Single-outstanding memory responder for the data cache with fixed ack-to-response latency.
module riscmakers_dcache_mem_responder
  import dcache_pkg::*;
#(
  parameter int unsigned MemLines = 1024,
  parameter int unsigned Latency  = RESP_DEFAULT_LATENCY
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_data_req_i,
  output logic         mem_data_ack_o,
  input  dcache_req_t  mem_data_i,
  output logic         mem_rtrn_vld_o,
  output dcache_rtrn_t mem_rtrn_o,
  output logic         err_o
);

  localparam int unsigned IdxW         = $clog2(MemLines);
  localparam int unsigned LineBytes    = DCACHE_LINE_WIDTH / 8;
  localparam int unsigned WordsPerLine = DCACHE_LINE_WIDTH / XLEN;
  localparam int unsigned WordSelW     = DCACHE_OFFSET_WIDTH - XLEN_ALIGN_BYTES;

  responder_state_t              state_q, state_d;
  logic [RESP_LATENCY_WIDTH-1:0] cnt_q, cnt_d;
  dcache_req_t                   req_q, req_d;

  logic idle_req, supported, respond, is_store;

  assign idle_req  = (state_q == IDLE) && mem_data_req_i && !rst_i;
  assign supported = (mem_data_i.rtype == DCACHE_LOAD_REQ) ||
                     (mem_data_i.rtype == DCACHE_STORE_REQ);
  assign respond   = (state_q == RESPOND) && !rst_i;
  assign is_store  = (req_q.rtype == DCACHE_STORE_REQ);

  assign mem_data_ack_o = idle_req;
  assign err_o          = idle_req && !supported;
  assign mem_rtrn_vld_o = respond;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (idle_req && supported) begin
          req_d   = mem_data_i;
          cnt_d   = RESP_LATENCY_WIDTH'(Latency - 1);
          // With a one-cycle latency the response must follow the ack directly.
          state_d = (Latency == 1) ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= RESP_LATENCY_WIDTH'(1)) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  logic [IdxW-1:0]              line_idx;
  logic [WordSelW-1:0]          word_sel;
  logic [XLEN_BYTES-1:0]        word_be;
  logic [LineBytes-1:0]         line_be;
  logic [DCACHE_LINE_WIDTH-1:0] line_wdata, line_rdata;

  // Upper address bits fall away here, so accesses alias modulo MemLines.
  assign line_idx   = req_q.paddr[DCACHE_OFFSET_WIDTH +: IdxW];
  assign word_sel   = req_q.paddr[XLEN_ALIGN_BYTES +: WordSelW];
  assign word_be    = store_be(req_q.size, req_q.paddr[XLEN_ALIGN_BYTES-1:0]);
  assign line_be    = LineBytes'(word_be) << {word_sel, {XLEN_ALIGN_BYTES{1'b0}}};
  assign line_wdata = {WordsPerLine{req_q.data}};

  riscmakers_line_sram #(
    .Lines(MemLines),
    .Width(DCACHE_LINE_WIDTH)
  ) u_line_sram (
    .clk_i   (clk_i),
    .we_i    (respond && is_store),
    .waddr_i (line_idx),
    .wbe_i   (line_be),
    .wdata_i (line_wdata),
    .raddr_i (line_idx),
    .rdata_o (line_rdata)
  );

  always_comb begin
    mem_rtrn_o = '0;
    if (respond) begin
      mem_rtrn_o.tid = req_q.tid;
      if (is_store) begin
        mem_rtrn_o.rtype = DCACHE_STORE_ACK;
      end else begin
        mem_rtrn_o.rtype = DCACHE_LOAD_ACK;
        mem_rtrn_o.data  = line_rdata;
      end
    end
  end

  logic unused_req;
  assign unused_req = ^{req_q.nc, req_q.paddr};

endmodule

// File: tb/tb_riscmakers_dcache_mem_responder.sv
// Randomized scoreboard bench for the data-cache memory responder, plus a Latency=1 instance.
module tb_riscmakers_dcache_mem_responder;
  import dcache_pkg::*;

  localparam int LAT    = 2;
  localparam int LINES  = 1024;
  localparam int LINES1 = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1, req = 1'b0, ack, vld, err;
  dcache_req_t  req_i = '0;
  dcache_rtrn_t rtrn;
  logic         rst1 = 1'b1, req1 = 1'b0, ack1, vld1, err1;
  dcache_req_t  req1_i = '0;
  dcache_rtrn_t rtrn1;

  always #5 clk = ~clk;

  riscmakers_dcache_mem_responder #(.MemLines(LINES), .Latency(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .mem_data_req_i(req), .mem_data_ack_o(ack),
    .mem_data_i(req_i), .mem_rtrn_vld_o(vld), .mem_rtrn_o(rtrn), .err_o(err)
  );

  riscmakers_dcache_mem_responder #(.MemLines(LINES1), .Latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .mem_data_req_i(req1), .mem_data_ack_o(ack1),
    .mem_data_i(req1_i), .mem_rtrn_vld_o(vld1), .mem_rtrn_o(rtrn1), .err_o(err1)
  );

  typedef struct {
    int                rdue;
    dcache_rtrn_type_t rtype;
    logic [127:0]      data;
    logic [3:0]        tid;
  } exp_t;

  exp_t         expq[$];
  logic [127:0] mem_model [LINES];
  int           checks = 0, errors = 0, cyc = 0, earliest = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (vld) begin
        if (expq.size() == 0) begin
          chk("unexpected_rtrn", 256'(1), 256'(0));
        end else begin
          e = expq.pop_front();
          chk("rtrn_cycle", 256'(cyc), 256'(e.rdue));
          chk("rtrn_rtype", 256'(rtrn.rtype), 256'(e.rtype));
          chk("rtrn_data", 256'(rtrn.data), 256'(e.data));
          chk("rtrn_tid", 256'(rtrn.tid), 256'(e.tid));
        end
      end else begin
        chk("rtrn_idle_zero", 256'(rtrn), 256'(0));
      end
      if (!ack) chk("err_idle", 256'(err), 256'(0));
    end
  end

  // Issue one request; called at posedge+1. Returns at posedge+1 of the cycle after the ack.
  task automatic send(input int rt, input int sz, input logic [31:0] pa, input logic [31:0] d,
                      input int t, input bit keep, input bit abort);
    int   exp_ack, ack_cyc, waited, idx, lb, lane;
    bit   sup;
    exp_t e;
    req_i.rtype = dcache_req_type_t'(rt[2:0]);
    req_i.size  = sz[2:0];
    req_i.paddr = pa;
    req_i.data  = d;
    req_i.tid   = t[3:0];
    req_i.nc    = 1'($urandom % 2);
    req         = 1'b1;
    exp_ack     = (cyc > earliest) ? cyc : earliest;
    waited      = 0;
    @(negedge clk);
    while (!ack && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ack) begin
      chk("ack_timeout", 256'(0), 256'(1));
      req = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    ack_cyc = cyc;
    chk("ack_cycle", 256'(ack_cyc), 256'(exp_ack));
    sup = (rt < 2);
    chk("err_pulse", 256'(err), 256'(!sup));
    idx = int'((pa >> 4) % LINES);
    if (sup && !abort) begin
      if (rt == 1) begin
        for (int b = 0; b < (1 << sz); b++) begin
          lb   = int'(pa % 16) + b;
          lane = int'(pa % 4) + b;
          mem_model[idx][8*lb +: 8] = d[8*lane +: 8];
        end
        e.rtype = DCACHE_STORE_ACK;
        e.data  = '0;
      end else begin
        e.rtype = DCACHE_LOAD_ACK;
        e.data  = mem_model[idx];
      end
      e.rdue = ack_cyc + LAT;
      e.tid  = t[3:0];
      expq.push_back(e);
    end
    earliest = ack_cyc + (sup ? LAT + 1 : 1);
    @(posedge clk);
    #1;
    if (!keep) req = 1'b0;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ack", 256'(ack), 256'(0));
      chk("midrst_vld", 256'(vld), 256'(0));
      chk("midrst_err", 256'(err), 256'(0));
      chk("midrst_rtrn", 256'(rtrn), 256'(0));
      @(posedge clk);
      #1;
      rst      = 1'b0;
      earliest = cyc;
    end
  endtask

  // Latency=1 instance: ack now, response exactly one cycle later.
  task automatic send1(input int rt, input logic [31:0] pa, input logic [31:0] d, input int t,
                       input logic [127:0] exp_data);
    req1_i.rtype = dcache_req_type_t'(rt[2:0]);
    req1_i.size  = 3'd2;
    req1_i.paddr = pa;
    req1_i.data  = d;
    req1_i.tid   = t[3:0];
    req1_i.nc    = 1'b0;
    req1         = 1'b1;
    @(negedge clk);
    chk("l1_ack", 256'(ack1), 256'(1));
    chk("l1_vld_in_ack", 256'(vld1), 256'(0));
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("l1_vld", 256'(vld1), 256'(1));
    chk("l1_rtype", 256'(rtrn1.rtype), 256'((rt == 1) ? DCACHE_STORE_ACK : DCACHE_LOAD_ACK));
    chk("l1_tid", 256'(rtrn1.tid), 256'(t[3:0]));
    chk("l1_data", 256'(rtrn1.data), 256'(exp_data));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          rt, sz, off, ln, gap;
    bit          keep;
    logic [31:0] pa, wd;

    // Reset state, with a request pending to confirm it is not acked.
    req         = 1'b1;
    req_i.rtype = DCACHE_LOAD_REQ;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 256'(ack), 256'(0));
      chk("rst_vld", 256'(vld), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_rtrn", 256'(rtrn), 256'(0));
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rst1     = 1'b0;
    req      = 1'b0;
    earliest = cyc;

    // Preload lines 0..7 word by word, back to back; line 4 gets the 0x0123..CDEF pattern.
    for (int l = 0; l < 8; l++) begin
      for (int w = 0; w < 4; w++) begin
        wd = (l == 4) ? ((w % 2 == 0) ? 32'h89AB_CDEF : 32'h0123_4567) : $urandom;
        send(1, 2, 32'(l * 16 + w * 4), wd, w, !(l == 7 && w == 3), 1'b0);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    send(0, 0, 32'h40, 32'h0, 1, 1'b0, 1'b0);
    send(1, 0, 32'h45, 32'h0000_AB00, 2, 1'b0, 1'b0);
    send(0, 0, 32'h40, 32'h0, 3, 1'b0, 1'b0);

    // Continuous request: acks spaced by Latency+1, tids returned in order.
    for (int i = 0; i < 6; i++) send(0, 0, 32'($urandom % 8) << 4, 32'h0, 4 + i, i < 5, 1'b0);

    // Reset one cycle after a store ack: store discarded, next request acked at once.
    send(1, 2, 32'h48, 32'hFFFF_FFFF, 7, 1'b0, 1'b1);
    send(0, 0, 32'h48, 32'h0, 8, 1'b0, 1'b0);

    // Unsupported rtype, then a normal load.
    send(3, 0, 32'h20, 32'h0, 9, 1'b1, 1'b0);
    send(0, 0, 32'h20, 32'h0, 10, 1'b0, 1'b0);

    // Aliased addresses above the index.
    send(0, 0, 32'h40 + 5 * 32'h4000, 32'h0, 11, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rt   = int'($urandom % 20);
      rt   = (rt < 9) ? 0 : (rt < 18) ? 1 : 2 + (rt % 2);
      sz   = int'($urandom % 3);
      off  = int'($urandom % 16) & ~((1 << sz) - 1);
      ln   = int'($urandom % 8);
      pa   = 32'(($urandom % 64) * 32'h4000 + 32'(ln * 16 + off));
      keep = 1'($urandom % 2);
      send(rt, sz, pa, $urandom, int'($urandom % 16), keep, 1'b0);
      if (!keep) begin
        gap = int'($urandom % 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("queue_drained", 256'(expq.size()), 256'(0));

    @(posedge clk);
    #1;
    send1(1, 32'h20, 32'h1111_0000, 1, 128'h0);
    send1(1, 32'h24, 32'h2222_0001, 2, 128'h0);
    send1(1, 32'h28, 32'h3333_0002, 3, 128'h0);
    send1(1, 32'h2C, 32'h4444_0003, 4, 128'h0);
    send1(0, 32'h20 + 32'(3 * LINES1 * 16), 32'h0, 5,
          {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000});
    send1(0, 32'h1234_0020, 32'h0, 6,
          {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
